// File: rtl/commit_ctrl_pkg.sv
// Shared definitions for the in-order commit sequencer: ROB head type codes,
// FSM state encoding and flush counter width.
package commit_ctrl_pkg;

   typedef enum logic [1:0] {
      HEAD_REG    = 2'b00,
      HEAD_STORE  = 2'b01,
      HEAD_BRANCH = 2'b10,
      HEAD_HALT   = 2'b11
   } head_type_t;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_WAIT_STORE = 2'b01,
      ST_ROLLBACK   = 2'b10,
      ST_HALTED     = 2'b11
   } state_t;

   // Holds FLUSH_CYCLES up to 15
   localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: one ROB head per cycle into the regfile,
// store handshake with the LSB, and mispredict recovery (link write, flush, redirect).
//
//  state         | meaning
//  --------------+------------------------------------------------------------
//  ST_IDLE       | accepting ready ROB heads
//  ST_WAIT_STORE | store_commit_req high, waiting for LSB ack
//  ST_ROLLBACK   | first cycle: link write only; then rollback held FLUSH_CYCLES
//  ST_HALTED     | HALT retired, no further accepts until rst
module commit_ctrl
   import commit_ctrl_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int REG_W        = 5,
   parameter int ROB_ID_W     = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                head_valid,
   input  logic                head_ready,
   input  logic [1:0]          head_type,
   input  logic [REG_W-1:0]    head_rd,
   input  logic [DATA_W-1:0]   head_value,
   input  logic [ROB_ID_W-1:0] head_robid,
   input  logic                head_mispredict,
   input  logic [DATA_W-1:0]   head_target_pc,
   output logic                commit_pop,
   output logic                rob_has_res,
   output logic [DATA_W-1:0]   result_from_rob,
   output logic [REG_W-1:0]    regidx_from_rob,
   output logic [ROB_ID_W-1:0] regalias_from_rob,
   output logic                store_commit_req,
   input  logic                store_commit_ack,
   output logic                rollback_signal,
   output logic                redirect_valid,
   output logic [DATA_W-1:0]   redirect_pc,
   output logic                halted,
   output logic [31:0]         commit_cnt
);

   state_t                 state, state_nxt;
   head_type_t             htype;
   logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
   logic                   res_q, res_nxt;
   logic [DATA_W-1:0]      data_q, data_nxt;
   logic [REG_W-1:0]       idx_q, idx_nxt;
   logic [ROB_ID_W-1:0]    tag_q, tag_nxt;
   logic                   req_q, req_nxt;
   logic                   rb_q, rb_nxt;
   logic                   redir_q, redir_nxt;
   logic [DATA_W-1:0]      pc_q, pc_nxt;
   logic                   halted_q, halted_nxt;
   logic [31:0]            cnt_q, cnt_nxt;
   logic                   pop;

   assign htype = head_type_t'(head_type);

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      res_nxt       = res_q;
      data_nxt      = data_q;
      idx_nxt       = idx_q;
      tag_nxt       = tag_q;
      req_nxt       = req_q;
      rb_nxt        = rb_q;
      redir_nxt     = redir_q;
      pc_nxt        = pc_q;
      halted_nxt    = halted_q;
      cnt_nxt       = cnt_q;
      pop           = 1'b0;

      if (rdy && !rst) begin
         res_nxt = 1'b0;
         case (state)
            ST_IDLE: begin
               if (head_valid && head_ready) begin
                  case (htype)
                     HEAD_REG, HEAD_BRANCH: begin
                        pop      = 1'b1;
                        res_nxt  = (head_rd != '0);
                        data_nxt = head_value;
                        idx_nxt  = head_rd;
                        tag_nxt  = head_robid;
                        if (htype == HEAD_BRANCH && head_mispredict) begin
                           pc_nxt    = head_target_pc;
                           state_nxt = ST_ROLLBACK;
                        end
                     end
                     HEAD_STORE: begin
                        req_nxt   = 1'b1;
                        state_nxt = ST_WAIT_STORE;
                     end
                     HEAD_HALT: begin
                        pop        = 1'b1;
                        halted_nxt = 1'b1;
                        state_nxt  = ST_HALTED;
                     end
                     default: ;
                  endcase
               end
            end
            ST_WAIT_STORE: begin
               if (store_commit_ack) begin
                  pop       = 1'b1;
                  req_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
            ST_ROLLBACK: begin
               // First cycle leaves room for the link write so it never overlaps rollback
               if (!rb_q) begin
                  rb_nxt        = 1'b1;
                  redir_nxt     = 1'b1;
                  flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES);
               end else begin
                  redir_nxt = 1'b0;
                  if (flush_cnt == FLUSH_CNT_W'(1)) begin
                     rb_nxt    = 1'b0;
                     state_nxt = ST_IDLE;
                  end else begin
                     flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
         cnt_nxt = cnt_q + 32'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
         res_q     <= 1'b0;
         data_q    <= '0;
         idx_q     <= '0;
         tag_q     <= '0;
         req_q     <= 1'b0;
         rb_q      <= 1'b0;
         redir_q   <= 1'b0;
         pc_q      <= '0;
         halted_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         res_q     <= res_nxt;
         data_q    <= data_nxt;
         idx_q     <= idx_nxt;
         tag_q     <= tag_nxt;
         req_q     <= req_nxt;
         rb_q      <= rb_nxt;
         redir_q   <= redir_nxt;
         pc_q      <= pc_nxt;
         halted_q  <= halted_nxt;
         cnt_q     <= cnt_nxt;
      end
   end

   // Pulses are held while frozen and only presented once rdy returns
   assign commit_pop        = pop;
   assign rob_has_res       = res_q & rdy;
   assign redirect_valid    = redir_q & rdy;
   assign result_from_rob   = data_q;
   assign regidx_from_rob   = idx_q;
   assign regalias_from_rob = tag_q;
   assign store_commit_req  = req_q;
   assign rollback_signal   = rb_q;
   assign redirect_pc       = pc_q;
   assign halted            = halted_q;
   assign commit_cnt        = cnt_q;

endmodule
